// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI write sequencer:
//   - seq_state_e    : frame controller state encoding
//   - *_DEF          : default frame geometry and interval lengths
//   - UNDERRUN_LIMIT : FETCH cycles without data before a frame is aborted
//                      (used only when SPI_SEQ_UNDERRUN_TIMEOUT_EN is defined)
//   - TMR_W          : width of the interval timer; intervals must fit in it
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_FETCH  = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_GAP    = 3'd5,
        S_HOLD   = 3'd6,
        S_FINISH = 3'd7
    } seq_state_e;

    localparam int MAX_LEN_DEF    = 16;
    localparam int CS_SETUP_DEF   = 2;
    localparam int GAP_DEF        = 1;
    localparam int CS_HOLD_DEF    = 2;
    localparam int UNDERRUN_LIMIT = 255;
    localparam int TMR_W          = 8;

    // Interval length as a timer load value.
    function automatic logic [TMR_W-1:0] tmr_cycles(input int cycles);
        return TMR_W'(cycles);
    endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// -----------------------------------------------------------------------------
// spi_seq_timer
// Loadable down-counter shared by the SETUP, GAP and HOLD intervals.
// Loading N makes done_o rise in the N-th cycle after the load edge, so a
// state entered together with the load lasts exactly N cycles.
// Ports:
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset
//   load_i     : load load_val_i this cycle (wins over counting)
//   load_val_i : interval length in cycles (>= 1)
//   done_o     : interval elapses at the coming edge
// -----------------------------------------------------------------------------
module spi_seq_timer
    import spi_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            // Saturates at zero instead of wrapping.
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/spi_write_sequencer.sv
// -----------------------------------------------------------------------------
// spi_write_sequencer
// Frames a multi-byte write with an active-low chip select: accepts a request
// with a byte count, pulls bytes from a valid/ready stream and fires the
// single-byte transmitter once per byte, with CS setup, inter-byte gap and CS
// hold intervals around the bytes.
//
// Optional feature (macro SPI_SEQ_UNDERRUN_TIMEOUT_EN): abort the frame with
// ERR when FETCH sees no data for UNDERRUN_LIMIT cycles. Without the macro,
// FETCH waits indefinitely with CS held low.
//
// Ports:
//   clk_i, rst_ni   : clock / asynchronous active-low reset
//   req_i, len_i    : frame request and byte count (1..MAX_LEN)
//   ack_o           : one-cycle pulse, request accepted
//   tx_data_i/valid : upstream byte stream; tx_ready_o is a Moore decode of FETCH
//   busy_o          : high from ACK through the FRAME_DONE cycle
//   frame_done_o    : one-cycle pulse, frame complete
//   err_o           : one-cycle pulse, rejected request or aborted frame
//   cs_n_o          : chip select, active-low
//   byte_start_o    : one-cycle start pulse to the byte transmitter
//   byte_data_o     : byte to send, stable from BYTE_START until BYTE_DONE
//   byte_done_i     : byte transmitter finished (one-cycle pulse)
// -----------------------------------------------------------------------------
module spi_write_sequencer
    import spi_pkg::*;
#(
    parameter int  MAX_LEN  = MAX_LEN_DEF,
    parameter int  CS_SETUP = CS_SETUP_DEF,
    parameter int  GAP      = GAP_DEF,
    parameter int  CS_HOLD  = CS_HOLD_DEF,
    localparam int LW       = $clog2(MAX_LEN + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_i,
    input  logic [LW-1:0] len_i,
    output logic          ack_o,
    input  logic [7:0]    tx_data_i,
    input  logic          tx_valid_i,
    output logic          tx_ready_o,
    output logic          busy_o,
    output logic          frame_done_o,
    output logic          err_o,
    output logic          cs_n_o,
    output logic          byte_start_o,
    output logic [7:0]    byte_data_o,
    input  logic          byte_done_i
);

    seq_state_e state_q, state_d;

    logic [LW-1:0] remaining_q, remaining_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          done_q, done_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          err_q, err_d;
    logic          cs_n_q, cs_n_d;
    logic          byte_start_q, byte_start_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;

    logic len_ok;
    logic handshake;
    logic done_take;
    logic underrun;

    assign len_ok    = (len_i != '0) && (len_i <= LW'(MAX_LEN));
    assign handshake = (state_q == S_FETCH) && tx_valid_i;
    // BYTE_DONE counts only once per byte and only while waiting for it.
    assign done_take = (state_q == S_WAIT) && byte_done_i && !done_q;

`ifdef SPI_SEQ_UNDERRUN_TIMEOUT_EN
    logic [7:0] uflow_q, uflow_d;

    // Counts consecutive FETCH cycles without data; any handshake or leaving
    // FETCH clears it.
    always_comb begin
        uflow_d = '0;
        if ((state_q == S_FETCH) && !tx_valid_i && !underrun) begin
            uflow_d = uflow_q + 8'd1;
        end
    end

    assign underrun = (state_q == S_FETCH) && !tx_valid_i &&
                      (uflow_q == 8'(UNDERRUN_LIMIT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            uflow_q <= '0;
        end else begin
            uflow_q <= uflow_d;
        end
    end
`else
    assign underrun = 1'b0;
`endif

    spi_seq_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            cs_n_q       <= 1'b1;
            byte_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            cs_n_q       <= cs_n_d;
            byte_start_q <= byte_start_d;
        end
    end

    // Next-state logic. The byte completion is registered (done_q) and acted
    // on one cycle later, when remaining_q already holds the decremented count.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (req_i && len_ok) state_d = S_SETUP;
            S_SETUP:  if (tmr_done) state_d = S_FETCH;
            S_FETCH: begin
                if (tx_valid_i) begin
                    state_d = S_START;
                end else if (underrun) begin
                    state_d = S_IDLE;
                end
            end
            S_START:  state_d = S_WAIT;
            S_WAIT: begin
                if (done_q) begin
                    if (remaining_q == '0) begin
                        state_d = S_HOLD;
                    end else if (GAP == 0) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP:    if (tmr_done) state_d = S_FETCH;
            S_HOLD:   if (tmr_done) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode: registered outputs follow the state being entered, so
    // each is valid in the same cycle as that state.
    always_comb begin
        ack_d        = (state_q == S_IDLE) && (state_d == S_SETUP);
        err_d        = ((state_q == S_IDLE) && req_i && !len_ok) || underrun;
        busy_d       = (state_d != S_IDLE);
        cs_n_d       = (state_d == S_IDLE) || (state_d == S_FINISH);
        frame_done_d = (state_d == S_FINISH);
        byte_start_d = (state_d == S_START);

        tmr_load = (state_d != state_q) &&
                   ((state_d == S_SETUP) || (state_d == S_GAP) || (state_d == S_HOLD));
        unique case (state_d)
            S_SETUP: tmr_val = tmr_cycles(CS_SETUP);
            S_GAP:   tmr_val = tmr_cycles(GAP);
            S_HOLD:  tmr_val = tmr_cycles(CS_HOLD);
            default: tmr_val = '0;
        endcase
    end

    // Byte datapath: count, captured byte and registered completion.
    always_comb begin
        remaining_d = remaining_q;
        if (ack_d) begin
            remaining_d = len_i;
        end else if (done_take && (remaining_q != '0)) begin
            remaining_d = remaining_q - LW'(1);
        end
        byte_data_d = handshake ? tx_data_i : byte_data_q;
        done_d      = done_take;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            remaining_q <= '0;
            byte_data_q <= '0;
            done_q      <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            byte_data_q <= byte_data_d;
            done_q      <= done_d;
        end
    end

    assign tx_ready_o   = (state_q == S_FETCH);
    assign ack_o        = ack_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign err_o        = err_q;
    assign cs_n_o       = cs_n_q;
    assign byte_start_o = byte_start_q;
    assign byte_data_o  = byte_data_q;

endmodule

// File: tb/tb_spi_write_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_write_sequencer
// Self-checking bench for spi_write_sequencer. Edges are numbered by cyc; an
// output "after edge n" is logged at the following falling edge. Expected
// edges come from a frame-level timing model built from the interval rules.
// Honours SPI_SEQ_UNDERRUN_TIMEOUT_EN when defined.
// -----------------------------------------------------------------------------
module tb_spi_write_sequencer;

    localparam int MAX_LEN  = 16;
    localparam int CS_SETUP = 2;
    localparam int GAP      = 1;
    localparam int CS_HOLD  = 2;
    localparam int LW       = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic [LW-1:0] len = '0;
    logic          ack;
    logic [7:0]    tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          busy;
    logic          frame_done;
    logic          err;
    logic          cs_n;
    logic          byte_start;
    logic [7:0]    byte_data;
    logic          byte_done = 1'b0;

    spi_write_sequencer #(
        .MAX_LEN  (MAX_LEN),
        .CS_SETUP (CS_SETUP),
        .GAP      (GAP),
        .CS_HOLD  (CS_HOLD)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .len_i        (len),
        .ack_o        (ack),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .err_o        (err),
        .cs_n_o       (cs_n),
        .byte_start_o (byte_start),
        .byte_data_o  (byte_data),
        .byte_done_i  (byte_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         dly;   // cycles the byte is withheld after becoming current
    } tx_item_t;

    tx_item_t items[$];    // bytes of the frame under test (model view)
    tx_item_t tx_q[$];     // bytes still to be offered by the source

    // Event logs.
    int         ack_q[$], fd_q[$], err_q[$], start_q[$];
    logic [7:0] sdata_q[$];
    int         cs_fall_q[$], cs_rise_q[$], busy_fall_q[$];
    int         unstable = 0;

    // Expected byte starts from the model.
    int         exp_start[$];
    logic [7:0] exp_data[$];

    // Source / transmitter model state.
    bit         hs_pending = 0;
    bit         cur_loaded = 0;
    int         hold = 0;
    int         bd_cnt = 0;
    int         bd_lat = 18;
    logic [7:0] cur_byte = '0;
    logic       prev_cs = 1'b1;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hs_pending = 0;
            cur_loaded = 0;
            hold       = 0;
            bd_cnt     = 0;
            byte_done  = 1'b0;
            tx_valid   = 1'b0;
        end else begin
            // Byte transmitter: BYTE_DONE sampled bd_lat edges after BYTE_START.
            if (byte_done) byte_done = 1'b0;
            if (bd_cnt > 0) begin
                bd_cnt--;
                if (bd_cnt == 0) byte_done = 1'b1;
            end
            if (byte_start) begin
                bd_cnt   = bd_lat - 1;
                cur_byte = byte_data;
            end else if ((bd_cnt > 0 || byte_done) && byte_data !== cur_byte) begin
                unstable++;
            end
            // Byte source.
            if (hs_pending) begin
                void'(tx_q.pop_front());
                cur_loaded = 0;
                hs_pending = 0;
            end
            if (cur_loaded && hold > 0) hold--;
            if (!cur_loaded && tx_q.size() > 0) begin
                hold       = tx_q[0].dly;
                cur_loaded = 1;
            end
            tx_valid   = cur_loaded && (hold == 0);
            tx_data    = tx_valid ? tx_q[0].data : 8'h00;
            hs_pending = tx_valid && tx_ready;
        end
        if (ack)        ack_q.push_back(cyc);
        if (frame_done) fd_q.push_back(cyc);
        if (err)        err_q.push_back(cyc);
        if (byte_start) begin
            start_q.push_back(cyc);
            sdata_q.push_back(byte_data);
        end
        if (cs_n !== prev_cs) begin
            if (cs_n === 1'b0) cs_fall_q.push_back(cyc);
            else               cs_rise_q.push_back(cyc);
            prev_cs = cs_n;
        end
        if (busy !== prev_busy) begin
            if (busy === 1'b0) busy_fall_q.push_back(cyc);
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        ack_q.delete(); fd_q.delete(); err_q.delete(); start_q.delete();
        sdata_q.delete(); cs_fall_q.delete(); cs_rise_q.delete();
        busy_fall_q.delete(); exp_start.delete(); exp_data.delete();
        unstable = 0;
    endtask

    // Frame timing model. k: accept edge; v0: first edge byte `first` is
    // sampled valid. FETCH opens CS_SETUP edges after accept and GAP+1 edges
    // after each BYTE_DONE; a byte starts at the first edge with FETCH open
    // and data valid; CS rises CS_HOLD+1 edges after the last BYTE_DONE.
    task automatic model_frame(input int k, input int v0, input int first, input int n,
                               input int lat, output int f, output int hlast);
        int open, v, h, j;
        open = k + CS_SETUP;
        v    = v0;
        h    = 0;
        j    = 0;
        for (int i = 0; i < n; i++) begin
            h = (open + 1 > v) ? open + 1 : v;
            exp_start.push_back(h);
            exp_data.push_back(items[first + i].data);
            j    = h + lat;
            open = j + GAP + 1;
            if (i + 1 < n) v = h + items[first + i + 1].dly + 1;
        end
        f     = j + CS_HOLD + 1;
        hlast = h;
    endtask

    task automatic verify_starts(input string tag);
        check({tag, "_start_cnt"}, start_q.size(), exp_start.size());
        for (int i = 0; i < exp_start.size(); i++) begin
            check($sformatf("%s_start%0d_edge", tag, i), start_q[i], exp_start[i]);
            check($sformatf("%s_start%0d_data", tag, i), sdata_q[i], exp_data[i]);
        end
        check({tag, "_data_stable"}, unstable, 0);
    endtask

    task automatic wait_fd(input string tag, input int want, input int budget);
        for (int t = 0; t < budget && fd_q.size() < want; t++) tick();
        check({tag, "_frame_done_seen"}, fd_q.size() >= want, 1);
        repeat (3) tick();
    endtask

    // Issues one frame from `items`, optionally with an ignored mid-frame REQ.
    task automatic do_frame(input string tag, input int n, input int lat, input bit stray);
        int c, k, f, hl;
        clear_logs();
        bd_lat = lat;
        tick();
        c = cyc;
        foreach (items[i]) tx_q.push_back(items[i]);
        req = 1'b1;
        len = LW'(n);
        tick();
        req = 1'b0;
        k = c + 1;
        if (stray) begin
            req = 1'b1;
            len = LW'($urandom_range(0, 31));
            tick();
            req = 1'b0;
        end
        wait_fd(tag, 1, 3000);
        model_frame(k, c + items[0].dly + 1, 0, n, lat, f, hl);
        check({tag, "_ack_cnt"}, ack_q.size(), 1);
        check({tag, "_ack_edge"}, ack_q[0], k);
        verify_starts(tag);
        check({tag, "_fd_cnt"}, fd_q.size(), 1);
        check({tag, "_fd_edge"}, fd_q[0], f);
        check({tag, "_cs_fall"}, cs_fall_q[0], k);
        check({tag, "_cs_rise"}, cs_rise_q[0], f);
        check({tag, "_cs_edges"}, cs_fall_q.size() + cs_rise_q.size(), 2);
        check({tag, "_busy_fall"}, busy_fall_q[0], f + 1);
        check({tag, "_err_cnt"}, err_q.size(), 0);
    endtask

    initial begin
        int c, k, f1, h1, f2, h2;
        logic [LW-1:0] bad_len[2];

        // Reset values.
        #12;
        check("rst_ack", ack, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_byte_start", byte_start, 1'b0);
        check("rst_byte_data", byte_data, 8'h00);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Three-byte frame with data always available.
        items.delete();
        items.push_back('{8'hA5, 0});
        items.push_back('{8'h3C, 0});
        items.push_back('{8'hFF, 0});
        do_frame("len3", 3, 18, 0);

        // Invalid lengths: ERR only.
        bad_len[0] = LW'(0);
        bad_len[1] = LW'(MAX_LEN + 1);
        for (int b = 0; b < 2; b++) begin
            clear_logs();
            tick();
            c = cyc;
            req = 1'b1;
            len = bad_len[b];
            tick();
            req = 1'b0;
            repeat (4) tick();
            check($sformatf("badlen%0d_err_cnt", b), err_q.size(), 1);
            check($sformatf("badlen%0d_err_edge", b), err_q[0], c + 1);
            check($sformatf("badlen%0d_ack_cnt", b), ack_q.size(), 0);
            check($sformatf("badlen%0d_cs_quiet", b), cs_fall_q.size(), 0);
        end

        // Second byte withheld for 40 cycles.
        items.delete();
        items.push_back('{8'h5A, 0});
        items.push_back('{8'hC3, 40});
        do_frame("starve", 2, 18, 0);

        // REQ held high across a LEN=1 frame: re-accepted right after FRAME_DONE.
        clear_logs();
        items.delete();
        items.push_back('{8'($urandom_range(0, 255)), 0});
        items.push_back('{8'($urandom_range(0, 255)), 0});
        bd_lat = 5;
        tick();
        c = cyc;
        foreach (items[i]) tx_q.push_back(items[i]);
        req = 1'b1;
        len = LW'(1);
        for (int t = 0; t < 500 && ack_q.size() < 2; t++) tick();
        req = 1'b0;
        wait_fd("reqhold", 2, 500);
        model_frame(c + 1, c + 1, 0, 1, 5, f1, h1);
        model_frame(f1 + 2, h1 + 1, 1, 1, 5, f2, h2);
        check("reqhold_ack_cnt", ack_q.size(), 2);
        check("reqhold_ack0_edge", ack_q[0], c + 1);
        check("reqhold_ack1_edge", ack_q[1], f1 + 2);
        check("reqhold_fd0_edge", fd_q[0], f1);
        check("reqhold_fd1_edge", fd_q[1], f2);
        verify_starts("reqhold");
        check("reqhold_err_cnt", err_q.size(), 0);

        // Reset while waiting on byte 2 of 4.
        clear_logs();
        items.delete();
        for (int i = 0; i < 4; i++) items.push_back('{8'($urandom_range(0, 255)), 0});
        bd_lat = 18;
        tick();
        foreach (items[i]) tx_q.push_back(items[i]);
        req = 1'b1;
        len = LW'(4);
        tick();
        req = 1'b0;
        for (int t = 0; t < 300 && start_q.size() < 2; t++) tick();
        check("rstmid_reached_byte2", start_q.size(), 2);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("rstmid_cs_n", cs_n, 1'b1);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_byte_start", byte_start, 1'b0);
        check("rstmid_tx_ready", tx_ready, 1'b0);
        repeat (3) tick();
        tx_q.delete();
        rst_n = 1'b1;
        repeat (2) tick();
        items.delete();
        items.push_back('{8'h96, 0});
        do_frame("after_rst", 1, 18, 0);

        // Randomized frames, including MAX_LEN and LEN=1, with a stray REQ.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = (r == 0) ? MAX_LEN : (r == 1) ? 1 : int'($urandom_range(1, MAX_LEN));
            items.delete();
            for (int i = 0; i < n; i++)
                items.push_back('{8'($urandom_range(0, 255)), int'($urandom_range(0, 4))});
            do_frame($sformatf("rand%0d", r), n, int'($urandom_range(2, 20)), 1);
        end

`ifdef SPI_SEQ_UNDERRUN_TIMEOUT_EN
        // No data ever offered: frame aborts after 255 FETCH cycles.
        clear_logs();
        tick();
        c = cyc;
        req = 1'b1;
        len = LW'(1);
        tick();
        req = 1'b0;
        k = c + 1;
        for (int t = 0; t < 400 && err_q.size() == 0; t++) tick();
        repeat (3) tick();
        check("uflow_ack_cnt", ack_q.size(), 1);
        check("uflow_err_cnt", err_q.size(), 1);
        check("uflow_err_edge", err_q[0], k + CS_SETUP + 255);
        check("uflow_cs_rise", cs_rise_q[0], k + CS_SETUP + 255);
        check("uflow_busy_fall", busy_fall_q[0], k + CS_SETUP + 255);
        check("uflow_fd_cnt", fd_q.size(), 0);
        check("uflow_start_cnt", start_q.size(), 0);
`else
        // No data for 300 cycles: FETCH keeps waiting with CS low, then completes.
        clear_logs();
        bd_lat = 6;
        tick();
        c = cyc;
        req = 1'b1;
        len = LW'(1);
        tick();
        req = 1'b0;
        k = c + 1;
        repeat (300) tick();
        check("nodata_err_cnt", err_q.size(), 0);
        check("nodata_cs_n", cs_n, 1'b0);
        check("nodata_busy", busy, 1'b1);
        check("nodata_tx_ready", tx_ready, 1'b1);
        items.delete();
        items.push_back('{8'h7E, 0});
        c = cyc;
        tx_q.push_back(items[0]);
        wait_fd("nodata", 1, 200);
        model_frame(k, c + 1, 0, 1, 6, f1, h1);
        verify_starts("nodata");
        check("nodata_fd_edge", fd_q[0], f1);
        check("nodata_cs_rise", cs_rise_q[0], f1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
